mac_dot_sequencer: RTL and testbench

- Sequences one signed fixed-point MAC datapath through a length-N dot product.
- Accepts a command carrying the length, then streams N operand pairs (a,b) under a valid/ready handshake.
- Hides the 2-stage multiply/accumulate latency and returns the accumulated sum under a result valid/ready handshake, with a sticky signed-overflow flag.
- Sits between a tile-level scheduler (command source and operand feeder) and the result writeback of a tensor tile.

---
 rtl/mac_seq_pkg.sv | 27 ++
 rtl/mac_dot_sequencer_mac_pipe.sv | 62 ++++++
 rtl/mac_dot_sequencer.sv | 94 +++++++++
 tb/tb_mac_dot_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and arithmetic helpers for the dot-product MAC sequencer.
// The helpers work on a 64-bit carrier so that one definition serves every width.
package mac_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_LEN_W       = 16;
    localparam int MAX_W           = 64;
    localparam int IDX_W           = $clog2(MAX_W);

    typedef logic signed [MAX_W-1:0] wide_t;

    // Treats bit from_w-1 of val as the sign bit and replicates it upward.
    function automatic wide_t sign_ext(input wide_t val, input int from_w);
        wide_t shl;
        shl = val <<< (MAX_W - from_w);
        return shl >>> (MAX_W - from_w);
    endfunction

    // Signed overflow of s = x + y at width w: equal-sign addends, differing sum sign.
    function automatic logic add_ovf(input wide_t x, input wide_t y, input wide_t s, input int w);
        return (x[IDX_W'(w-1)] == y[IDX_W'(w-1)]) && (s[IDX_W'(w-1)] != x[IDX_W'(w-1)]);
    endfunction

endpackage

// File: rtl/mac_dot_sequencer_mac_pipe.sv
// Two-stage signed MAC: registered product, then wrapping accumulate with a
// sticky overflow flag. Accumulator clear takes priority over accumulate.
module mac_pipe
    import mac_seq_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_vld,
    input  logic [INPUT_WIDTH-1:0] a,
    input  logic [INPUT_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]   acc,
    output logic                   ovf
);

    localparam int PW = 2 * INPUT_WIDTH;

    logic signed [PW-1:0]        prod_p0;
    logic                        vld_p0;
    logic signed [ACC_WIDTH-1:0] acc_p1;
    logic                        ovf_p1;
    logic signed [ACC_WIDTH-1:0] addend;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        ovf_step;
    wide_t                       prod_w;

    always_comb begin
        prod_w   = sign_ext(wide_t'({{(MAX_W-PW){1'b0}}, prod_p0}), PW);
        addend   = $signed(prod_w[ACC_WIDTH-1:0]);
        sum      = acc_p1 + addend;
        ovf_step = add_ovf(wide_t'(acc_p1), wide_t'(addend), wide_t'(sum), ACC_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p0 <= '0;
            vld_p0  <= 1'b0;
            acc_p1  <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            // stage p0: product of the accepted beat
            vld_p0 <= in_vld;
            if (in_vld)
                prod_p0 <= PW'($signed(a)) * PW'($signed(b));
            // stage p1: accumulate the product registered one cycle earlier
            if (clr) begin
                acc_p1 <= '0;
                ovf_p1 <= 1'b0;
            end else if (vld_p0) begin
                acc_p1 <= sum;
                ovf_p1 <= ovf_p1 | ovf_step;
            end
        end
    end

    assign acc = acc_p1;
    assign ovf = ovf_p1;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Runs a length-N signed dot product through mac_pipe: command in, N operand
// beats, one result out once the last product has been accumulated.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int LEN_W       = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [INPUT_WIDTH-1:0] op_a,
    input  logic [INPUT_WIDTH-1:0] op_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_WIDTH-1:0]   res_sum,
    output logic                   res_ovf,
    output logic                   busy
);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             beat;
    logic             accept;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    assign beat      = op_valid && op_ready;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    mac_pipe #(
        .INPUT_WIDTH(INPUT_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .in_vld(beat),
        .a     (op_a),
        .b     (op_b),
        .acc   (res_sum),
        .ovf   (res_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            cmd_ready <= 1'b0;
            op_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= RUN;
                            op_ready <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state    <= DRAIN;
                            op_ready <= 1'b0;
                        end
                    end
                end
                // the last product is added into the accumulator during DRAIN
                DRAIN: state <= DONE;
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: a 32-bit and a 16-bit accumulator
// instance share all inputs, so every vector checks wrap/overflow at both widths.
module tb_mac_dot_sequencer;

    localparam int IW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          op_valid;
    logic [IW-1:0] op_a;
    logic [IW-1:0] op_b;
    logic          res_ready;

    logic          cmd_ready, op_ready, res_valid, res_ovf, busy;
    logic [31:0]   res_sum;
    logic          cmd_ready16, op_ready16, res_valid16, res_ovf16, busy16;
    logic [15:0]   res_sum16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer #(.INPUT_WIDTH(IW), .ACC_WIDTH(32), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_ovf(res_ovf), .busy(busy)
    );

    mac_dot_sequencer #(.INPUT_WIDTH(IW), .ACC_WIDTH(16), .LEN_W(LW)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready16), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready16), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid16), .res_ready(res_ready), .res_sum(res_sum16),
        .res_ovf(res_ovf16), .busy(busy16)
    );

    typedef struct {
        int     len;
        int     gap;
        int     a[4];
        int     b[4];
        longint s32;
        longint s16;
        logic   o32;
        logic   o16;
    } vec_t;

    vec_t vecs[6];
    vec_t hold_v;
    vec_t post_rst_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check_bit("cmd_ready_wait", cmd_ready, 1'b1);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check_bit({tag, "_res_valid"}, res_valid, 1'b1);
        check_bit({tag, "_res_valid16"}, res_valid16, 1'b1);
        check_val({tag, "_sum32"}, longint'($signed(res_sum)), v.s32);
        check_bit({tag, "_ovf32"}, res_ovf, v.o32);
        check_val({tag, "_sum16"}, longint'($signed(res_sum16)), v.s16);
        check_bit({tag, "_ovf16"}, res_ovf16, v.o16);
    endtask

    // One full command; hold > 0 keeps res_ready low that many cycles in DONE.
    task automatic run_cmd(input string tag, input vec_t v, input int hold);
        wait_ready();
        cmd_len   = LW'(v.len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_bit({tag, "_busy"}, busy, 1'b1);
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    op_valid = 1'b0;
                    tick();
                end
            end
            check_bit({tag, "_op_ready"}, op_ready, 1'b1);
            op_valid = 1'b1;
            op_a     = IW'(v.a[i]);
            op_b     = IW'(v.b[i]);
            tick();
        end
        op_valid = 1'b0;
        check_bit({tag, "_res_valid_early"}, res_valid, 1'b0);
        tick();
        check_bit({tag, "_op_ready_off"}, op_ready, 1'b0);
        check_result(tag, v);
        for (int h = 0; h < hold; h++) begin
            if (h == 3) begin
                cmd_len   = LW'(0);
                cmd_valid = 1'b1;
            end
            tick();
            cmd_valid = 1'b0;
            check_bit({tag, "_hold_valid"}, res_valid, 1'b1);
            check_bit({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
            check_val({tag, "_hold_sum32"}, longint'($signed(res_sum)), v.s32);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_bit({tag, "_pop_res_valid"}, res_valid, 1'b0);
        check_bit({tag, "_pop_cmd_ready"}, cmd_ready, 1'b1);
        check_bit({tag, "_pop_busy"}, busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check_bit({tag, "_op_ready"}, op_ready, 1'b0);
        check_bit({tag, "_res_valid"}, res_valid, 1'b0);
        check_val({tag, "_sum32"}, longint'($signed(res_sum)), 0);
        check_bit({tag, "_ovf32"}, res_ovf, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_sum16"}, longint'($signed(res_sum16)), 0);
        check_bit({tag, "_busy16"}, busy16, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4, 0, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 70, 70, 1'b0, 1'b0};
        vecs[1] = '{3, 2, '{-128, 127, -1, 0}, '{-128, -128, 1, 0}, 127, 127, 1'b0, 1'b0};
        vecs[2] = '{2, 1, '{-5, 7, 0, 0}, '{9, -3, 0, 0}, -66, -66, 1'b0, 1'b0};
        vecs[3] = '{4, 0, '{127, 127, 127, 127}, '{127, 127, 127, 127}, 64516, -1020, 1'b0, 1'b1};
        vecs[4] = '{2, 0, '{-128, -128, 0, 0}, '{-128, -128, 0, 0}, 32768, -32768, 1'b0, 1'b1};
        vecs[5] = '{1, 0, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 1, 1, 1'b0, 1'b0};
        hold_v     = '{1, 0, '{6, 0, 0, 0}, '{7, 0, 0, 0}, 42, 42, 1'b0, 1'b0};
        post_rst_v = '{1, 0, '{3, 0, 0, 0}, '{4, 0, 0, 0}, 12, 12, 1'b0, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check_bit("cmd_ready_after_reset", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("v%0d", i), vecs[i], 0);

        // zero-length command: straight to DONE, never opens the operand port
        wait_ready();
        cmd_len   = LW'(0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_bit("len0_res_valid", res_valid, 1'b1);
            check_val("len0_sum32", longint'($signed(res_sum)), 0);
            check_bit("len0_ovf", res_ovf, 1'b0);
            check_bit("len0_op_ready", op_ready, 1'b0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_bit("len0_pop_cmd_ready", cmd_ready, 1'b1);

        run_cmd("hold", hold_v, 10);

        // abort a 5-beat command after 2 beats
        wait_ready();
        cmd_len   = LW'(5);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1;
            op_a     = IW'(9);
            op_b     = IW'(9);
            tick();
        end
        op_valid = 1'b0;
        check_val("pre_abort_sum32", longint'($signed(res_sum)), 81);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check_bit("abort_cmd_ready", cmd_ready, 1'b1);
        run_cmd("post_rst", post_rst_v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
